accumulator_bus_scheduler: RTL and testbench

Round-robin bus scheduler for the shared accumulator memory bus. It arbitrates up to N_REQ accumulator processors and grants exclusive bus ownership to one at a time for a whole transaction, not a single cycle. It enforces a hold limit with forced preemption and a turnaround gap between owners so the tri-stated read/write buses never see two drivers. It sits between the processors' req/grant pins and the memory's bus clock domain, and is clocked by the bus clock.

---
 rtl/accumulator_bus_scheduler.sv | 168 ++++++++++++++++
 tb/tb_accumulator_bus_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_bus_scheduler.sv
// Round-robin owner scheduler for the shared accumulator memory bus.
// A grant is held for a whole transaction. It ends when the owner signals done,
// when the owner drops its request, or when the hold limit is reached.
// The bus then idles for a turnaround gap before the next owner is chosen.
module accumulator_bus_scheduler #(
   parameter  int N_REQ       = 4,
   parameter  int MAX_HOLD    = 16,
   parameter  int TURN_CYCLES = 1,
   localparam int OW          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] grant,
   output logic             busy,
   output logic [OW-1:0]    owner,
   output logic             timeout,
   output logic [15:0]      grant_count
);

   localparam int HW = $clog2(MAX_HOLD);
   localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic             busy_q, busy_d;
   logic [OW-1:0]    owner_q, owner_d;
   logic [OW-1:0]    ptr_q, ptr_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [TW-1:0]    turn_q, turn_d;
   logic             timeout_q, timeout_d;
   logic [15:0]      count_q, count_d;

   logic             pick_found_s;
   logic [OW-1:0]    pick_idx_s;
   logic [OW-1:0]    ptr_next_s;
   logic             rel_done_s, rel_req_s, rel_hold_s;
   int               scan_idx;

   // Rotating scan starting at the priority pointer; the first set request wins.
   always_comb begin
      pick_found_s = 1'b0;
      pick_idx_s   = '0;
      scan_idx     = 0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_idx = int'(ptr_q) + k;
         if (scan_idx >= N_REQ) begin
            scan_idx = scan_idx - N_REQ;
         end else begin
            scan_idx = scan_idx;
         end
         if (!pick_found_s && req[OW'(scan_idx)]) begin
            pick_found_s = 1'b1;
            pick_idx_s   = OW'(scan_idx);
         end else begin
            pick_found_s = pick_found_s;
         end
      end
   end

   // Release causes for the current owner, plus the next pointer. The next
   // pointer makes the departing owner the lowest priority in the next scan.
   always_comb begin
      rel_done_s = done[owner_q];
      rel_req_s  = ~req[owner_q];
      rel_hold_s = (hold_q == HW'(MAX_HOLD - 1));
      if (owner_q == OW'(N_REQ - 1)) begin
         ptr_next_s = '0;
      end else begin
         ptr_next_s = owner_q + {{(OW-1){1'b0}}, 1'b1};
      end
   end

   // Next-state and registered-output logic for the IDLE/GRANT/TURN sequence.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      turn_d    = turn_q;
      timeout_d = 1'b0;
      count_d   = count_q;
      case (state_q)
         ST_IDLE: begin
            if (enable && pick_found_s) begin
               grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
               owner_d = pick_idx_s;
               hold_d  = '0;
               if (count_q != 16'hFFFF) begin
                  count_d = count_q + 16'd1;
               end else begin
                  count_d = count_q;
               end
               state_d = ST_GRANT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (rel_done_s || rel_req_s || rel_hold_s) begin
               grant_d   = '0;
               ptr_d     = ptr_next_s;
               turn_d    = '0;
               // A forced revoke is flagged only when nothing else ended the grant.
               timeout_d = rel_hold_s & ~rel_done_s & ~rel_req_s;
               state_d   = ST_TURN;
            end else begin
               hold_d  = hold_q + {{(HW-1){1'b0}}, 1'b1};
               state_d = ST_GRANT;
            end
         end
         ST_TURN: begin
            if (turn_q == TW'(TURN_CYCLES - 1)) begin
               state_d = ST_IDLE;
            end else begin
               turn_d  = turn_q + {{(TW-1){1'b0}}, 1'b1};
               state_d = ST_TURN;
            end
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
      busy_d = |grant_d;
   end

   // State and output registers; reset clears everything asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         owner_q   <= '0;
         ptr_q     <= '0;
         hold_q    <= '0;
         turn_q    <= '0;
         timeout_q <= 1'b0;
         count_q   <= 16'd0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         turn_q    <= turn_d;
         timeout_q <= timeout_d;
         count_q   <= count_d;
      end
   end

   assign grant       = grant_q;
   assign busy        = busy_q;
   assign owner       = owner_q;
   assign timeout     = timeout_q;
   assign grant_count = count_q;

endmodule

// File: tb/tb_accumulator_bus_scheduler.sv
// Bench for accumulator_bus_scheduler (N_REQ=4, MAX_HOLD=16, TURN_CYCLES=1).
// A transaction table drives requests and done strobes. Expected owners are
// queued when stimulus is applied and popped whenever a new grant rises.
module tb_accumulator_bus_scheduler;

   localparam int N_REQ       = 4;
   localparam int MAX_HOLD    = 16;
   localparam int TURN_CYCLES = 1;

   logic       clk = 1'b0;
   logic       reset_r;
   logic       enable_r;
   logic [3:0] req_r;
   logic [3:0] done_r;
   logic [3:0] grant;
   logic       busy;
   logic [1:0] owner;
   logic       timeout;
   logic [15:0] grant_count;

   int checks = 0;
   int errors = 0;
   logic [1:0] exp_q[$];
   logic prev_busy = 1'b0;
   logic last_to   = 1'b0;

   typedef struct {
      logic [3:0] req;
      int         done_cyc;   // grant cycle on which done[owner] is pulsed, 0 = never
      int         drop_cyc;   // grant cycle on which req[owner] is dropped, 0 = never
      logic [1:0] own;
      int         len;
      logic       to;
      logic       gap;        // check minimal turnaround before this grant
   } txn_t;

   txn_t tbl [13];

   accumulator_bus_scheduler #(
      .N_REQ(N_REQ), .MAX_HOLD(MAX_HOLD), .TURN_CYCLES(TURN_CYCLES)
   ) dut (
      .clk(clk), .reset(reset_r), .enable(enable_r), .req(req_r), .done(done_r),
      .grant(grant), .busy(busy), .owner(owner), .timeout(timeout),
      .grant_count(grant_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: owner/grant consistency and owner order on each new grant.
   always @(negedge clk) begin
      if (reset_r) begin
         prev_busy = 1'b0;
      end else begin
         chk("busy_vs_grant", {31'd0, busy}, {31'd0, |grant});
         if (grant != 4'd0) chk("grant_onehot_owner", {28'd0, grant}, 32'd1 << owner);
         if (grant != 4'd0 && !prev_busy) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_owner: unexpected grant %b, no expected entry", grant);
            end else begin
               chk("sb_owner", {30'd0, owner}, {30'd0, exp_q.pop_front()});
            end
         end
         prev_busy = (grant != 4'd0);
      end
   end

   task automatic wait_grant(output int gap);
      bit got = 1'b0;
      gap = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0 && last_to) chk("timeout_one_cycle", {31'd0, timeout}, 32'd0);
         if (grant != 4'd0) begin
            got = 1'b1;
            break;
         end
         gap++;
      end
      last_to = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL grant_wait: no grant within 40 cycles, got 0 expected grant");
      end
   endtask

   task automatic run_txn(input txn_t t);
      int gap;
      int len = 0;
      exp_q.push_back(t.own);
      req_r = t.req;
      wait_grant(gap);
      if (t.gap) chk("turn_gap", gap, TURN_CYCLES);
      while (grant != 4'd0 && len < 40) begin
         len++;
         if (len == t.done_cyc) done_r = 4'b0001 << t.own;
         if (len == t.drop_cyc) req_r[t.own] = 1'b0;
         @(posedge clk);
         #1 done_r = 4'd0;
         @(negedge clk);
      end
      chk("grant_len", len, t.len);
      chk("timeout", {31'd0, timeout}, {31'd0, t.to});
      last_to = t.to;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_r = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset_r = 1'b0;
      exp_q.delete();
      last_to = 1'b0;
   endtask

   initial begin
      int   gap;
      txn_t t;
      reset_r  = 1'b1;
      enable_r = 1'b1;
      req_r    = 4'd0;
      done_r   = 4'd0;

      // Transaction table: rotation, single requester, timeout, coincident limit,
      // request-drop release, then two more pointer-order cases.
      tbl[0]  = '{4'b1111,  2, 0, 2'd0,  2, 1'b0, 1'b0};
      tbl[1]  = '{4'b1111,  2, 0, 2'd1,  2, 1'b0, 1'b1};
      tbl[2]  = '{4'b1111,  2, 0, 2'd2,  2, 1'b0, 1'b1};
      tbl[3]  = '{4'b1111,  2, 0, 2'd3,  2, 1'b0, 1'b1};
      tbl[4]  = '{4'b1111,  2, 0, 2'd0,  2, 1'b0, 1'b1};
      tbl[5]  = '{4'b0100,  3, 0, 2'd2,  3, 1'b0, 1'b1};
      tbl[6]  = '{4'b0100,  3, 0, 2'd2,  3, 1'b0, 1'b1};
      tbl[7]  = '{4'b0001,  0, 0, 2'd0, 16, 1'b1, 1'b1};
      tbl[8]  = '{4'b0001,  0, 0, 2'd0, 16, 1'b1, 1'b1};
      tbl[9]  = '{4'b0001, 16, 0, 2'd0, 16, 1'b0, 1'b1};
      tbl[10] = '{4'b0010,  0, 4, 2'd1,  4, 1'b0, 1'b1};
      tbl[11] = '{4'b1000,  1, 0, 2'd3,  1, 1'b0, 1'b1};
      tbl[12] = '{4'b1001,  1, 0, 2'd0,  1, 1'b0, 1'b1};

      #1;
      chk("rst_grant",   {28'd0, grant}, 32'd0);
      chk("rst_busy",    {31'd0, busy}, 32'd0);
      chk("rst_owner",   {30'd0, owner}, 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
      chk("rst_count",   {16'd0, grant_count}, 32'd0);
      @(negedge clk);
      reset_r = 1'b0;

      // Grant owner 2 so the pointer moves to 3, then reset in the middle of a grant to 3.
      t = '{4'b0100, 1, 0, 2'd2, 1, 1'b0, 1'b0};
      run_txn(t);
      exp_q.push_back(2'd3);
      req_r = 4'b1010;
      wait_grant(gap);
      chk("pre_rst_count", {16'd0, grant_count}, 32'd2);
      reset_r = 1'b1;
      #1;
      chk("async_rst_grant",   {28'd0, grant}, 32'd0);
      chk("async_rst_busy",    {31'd0, busy}, 32'd0);
      chk("async_rst_timeout", {31'd0, timeout}, 32'd0);
      chk("async_rst_count",   {16'd0, grant_count}, 32'd0);
      @(negedge clk);
      reset_r = 1'b0;
      exp_q.delete();
      // Pointer back at 0: with req 1010 the scan must pick 1, not 3.
      t = '{4'b1010, 1, 0, 2'd1, 1, 1'b0, 1'b0};
      run_txn(t);
      chk("post_rst_count", {16'd0, grant_count}, 32'd1);

      do_reset();
      for (int i = 0; i < 13; i++) begin
         run_txn(tbl[i]);
      end
      chk("table_count", {16'd0, grant_count}, 32'd13);

      // Enable gating: grant to 3 completes, nothing issued while disabled.
      do_reset();
      exp_q.push_back(2'd3);
      req_r = 4'b1000;
      wait_grant(gap);
      enable_r = 1'b0;
      req_r    = 4'b1111;
      done_r   = 4'b1000;
      @(posedge clk);
      #1 done_r = 4'd0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0 || i == 9) chk("disabled_no_grant", {28'd0, grant}, 32'd0);
      end
      exp_q.push_back(2'd0);
      enable_r = 1'b1;
      wait_grant(gap);
      chk("enable_regrant_owner", {30'd0, owner}, 32'd0);
      chk("enable_count", {16'd0, grant_count}, 32'd2);
      req_r = 4'd0;
      @(negedge clk);
      @(negedge clk);
      chk("sb_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
